safebox_code_entry: RTL and testbench

//  Consumer of the single-cycle key pulses produced by the key debouncers.

---
 rtl/safebox_code_entry.sv | 114 +++++++++++
 tb/tb_safebox_code_entry.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/safebox_code_entry.sv
// Safe-box code entry: assembles a 4-digit BCD code from debounced key pulses,
// checks it against a stored password and enforces a timed lockout after repeated failures.
module safebox_code_entry #(
    parameter logic [15:0] PASS_DEFAULT = 16'h1234,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned LOCK_CYC     = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_inc,
    input  logic        key_next,
    input  logic        key_ok,
    input  logic        key_set,
    output logic [15:0] code_disp,
    output logic [1:0]  pos,
    output logic        unlocked,
    output logic        alarm,
    output logic [1:0]  fail_cnt
);

    localparam int unsigned TW = $clog2(LOCK_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_CYC - 1);
    localparam logic [2:0] TRIES_LIMIT = 3'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_LOCKED
    } state_t;

    state_t        state;
    logic [15:0]   entry;
    logic [15:0]   pass;
    logic [TW-1:0] timer;

    // Illegal BCD values 10..15 fold back to 0 together with the 9 -> 0 wrap.
    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ENTRY;
            entry    <= '0;
            pos      <= '0;
            pass     <= PASS_DEFAULT;
            fail_cnt <= '0;
            timer    <= '0;
            unlocked <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            case (state)
                ST_ENTRY: begin
                    if (key_ok) begin
                        entry <= '0;
                        pos   <= '0;
                        if (entry == pass) begin
                            state    <= ST_OPEN;
                            unlocked <= 1'b1;
                            fail_cnt <= '0;
                        end else if (({1'b0, fail_cnt} + 3'd1) == TRIES_LIMIT) begin
                            state    <= ST_LOCKED;
                            alarm    <= 1'b1;
                            fail_cnt <= TRIES_LIMIT[1:0];
                            timer    <= '0;
                        end else begin
                            fail_cnt <= fail_cnt + 2'd1;
                        end
                    end else if (key_set) begin
                        // SET outranks NEXT/INC even though it has no effect here.
                    end else if (key_next) begin
                        pos <= pos + 2'd1;
                    end else if (key_inc) begin
                        entry[{pos, 2'b00} +: 4] <= inc_digit(entry[{pos, 2'b00} +: 4]);
                    end
                end
                ST_OPEN: begin
                    if (key_ok) begin
                        state    <= ST_ENTRY;
                        unlocked <= 1'b0;
                        entry    <= '0;
                        pos      <= '0;
                    end else if (key_set) begin
                        pass  <= entry;
                        entry <= '0;
                        pos   <= '0;
                    end else if (key_next) begin
                        pos <= pos + 2'd1;
                    end else if (key_inc) begin
                        entry[{pos, 2'b00} +: 4] <= inc_digit(entry[{pos, 2'b00} +: 4]);
                    end
                end
                ST_LOCKED: begin
                    if (timer == TIMER_LAST) begin
                        state    <= ST_ENTRY;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_ENTRY;
                    unlocked <= 1'b0;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

    assign code_disp = entry;

endmodule

// File: tb/tb_safebox_code_entry.sv
// Bench for safebox_code_entry: table vectors, directed corner sequences and
// random key streams checked against a digit-array reference model.
module tb_safebox_code_entry;

    localparam int LOCK = 8;
    localparam int TRIES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_inc = 1'b0, key_next = 1'b0, key_ok = 1'b0, key_set = 1'b0;
    logic [15:0] code_disp;
    logic [1:0]  pos;
    logic        unlocked, alarm;
    logic [1:0]  fail_cnt;

    int vectors = 0;
    int miscompares = 0;

    safebox_code_entry #(.LOCK_CYC(LOCK)) dut (
        .clk(clk), .rst(rst),
        .key_inc(key_inc), .key_next(key_next), .key_ok(key_ok), .key_set(key_set),
        .code_disp(code_disp), .pos(pos), .unlocked(unlocked), .alarm(alarm),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = ENTRY, 1 = OPEN, 2 = LOCKED
    int m_dig[4];
    int m_pass[4];
    int m_pos, m_mode, m_fail, m_left;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_pass[3] = 1; m_pass[2] = 2; m_pass[1] = 3; m_pass[0] = 4;
        m_pos = 0; m_mode = 0; m_fail = 0; m_left = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_pos = 0;
    endtask

    task automatic model_step(input bit ok, input bit set, input bit nxt, input bit inc);
        bit match;
        if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 0;
                m_fail = 0;
            end
        end else if (ok) begin
            if (m_mode == 0) begin
                match = 1;
                for (int i = 0; i < 4; i++) if (m_dig[i] != m_pass[i]) match = 0;
                if (match) begin
                    m_mode = 1;
                    m_fail = 0;
                end else begin
                    m_fail++;
                    if (m_fail == TRIES) begin
                        m_mode = 2;
                        m_left = LOCK;
                    end
                end
            end else begin
                m_mode = 0;
            end
            model_clear();
        end else if (set) begin
            if (m_mode == 1) begin
                for (int i = 0; i < 4; i++) m_pass[i] = m_dig[i];
                model_clear();
            end
        end else if (nxt) begin
            m_pos = (m_pos + 1) % 4;
        end else if (inc) begin
            m_dig[m_pos] = (m_dig[m_pos] + 1) % 10;
        end
    endtask

    function automatic logic [15:0] model_code();
        return 16'(m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
    endfunction

    task automatic check(input string name, input logic [15:0] e_code, input logic [1:0] e_pos,
                         input logic e_unl, input logic e_alarm, input logic [1:0] e_fail);
        vectors++;
        if (code_disp !== e_code) begin
            miscompares++;
            $display("FAIL %s code_disp: got %h expected %h", name, code_disp, e_code);
        end
        if (pos !== e_pos) begin
            miscompares++;
            $display("FAIL %s pos: got %0d expected %0d", name, pos, e_pos);
        end
        if (unlocked !== e_unl) begin
            miscompares++;
            $display("FAIL %s unlocked: got %b expected %b", name, unlocked, e_unl);
        end
        if (alarm !== e_alarm) begin
            miscompares++;
            $display("FAIL %s alarm: got %b expected %b", name, alarm, e_alarm);
        end
        if (fail_cnt !== e_fail) begin
            miscompares++;
            $display("FAIL %s fail_cnt: got %0d expected %0d", name, fail_cnt, e_fail);
        end
    endtask

    task automatic check_model(input string name);
        check(name, model_code(), 2'(m_pos), m_mode == 1, m_mode == 2, 2'(m_fail));
    endtask

    // Drives one cycle of key pulses, advances the model across the same edge.
    task automatic apply(input bit ok, input bit set, input bit nxt, input bit inc);
        key_ok = ok; key_set = set; key_next = nxt; key_inc = inc;
        @(posedge clk);
        #1;
        key_ok = 0; key_set = 0; key_next = 0; key_inc = 0;
        model_step(ok, set, nxt, inc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Assumes a cleared entry with the cursor at digit 0; leaves the cursor back at 0.
    task automatic enter_code(input logic [15:0] code);
        for (int d = 0; d < 4; d++) begin
            repeat (int'(code[4*d +: 4])) begin
                apply(0, 0, 0, 1);
                check_model("enter_inc");
            end
            apply(0, 0, 1, 0);
            check_model("enter_next");
        end
    endtask

    typedef struct {
        bit ok, set, nxt, inc;
        logic [15:0] code;
        logic [1:0] p;
        logic unl, alm;
        logic [1:0] fc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int alarm_cycles;
        int r;

        tbl[0]  = '{0,0,0,1, 16'h0001, 2'd0, 0, 0, 2'd0};
        tbl[1]  = '{0,0,1,0, 16'h0001, 2'd1, 0, 0, 2'd0};
        tbl[2]  = '{0,0,0,1, 16'h0011, 2'd1, 0, 0, 2'd0};
        tbl[3]  = '{0,0,0,1, 16'h0021, 2'd1, 0, 0, 2'd0};
        tbl[4]  = '{0,0,1,0, 16'h0021, 2'd2, 0, 0, 2'd0};
        tbl[5]  = '{0,0,0,1, 16'h0121, 2'd2, 0, 0, 2'd0};
        tbl[6]  = '{0,0,0,1, 16'h0221, 2'd2, 0, 0, 2'd0};
        tbl[7]  = '{0,0,0,1, 16'h0321, 2'd2, 0, 0, 2'd0};
        tbl[8]  = '{0,0,1,0, 16'h0321, 2'd3, 0, 0, 2'd0};
        tbl[9]  = '{0,0,0,1, 16'h1321, 2'd3, 0, 0, 2'd0};
        tbl[10] = '{0,0,0,1, 16'h2321, 2'd3, 0, 0, 2'd0};
        tbl[11] = '{0,0,0,1, 16'h3321, 2'd3, 0, 0, 2'd0};
        tbl[12] = '{0,0,0,1, 16'h4321, 2'd3, 0, 0, 2'd0};
        tbl[13] = '{1,0,0,0, 16'h0000, 2'd0, 0, 0, 2'd1};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("reset", 16'h0000, 2'd0, 0, 0, 2'd0);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].ok, tbl[i].set, tbl[i].nxt, tbl[i].inc);
            check($sformatf("table[%0d]", i), tbl[i].code, tbl[i].p, tbl[i].unl, tbl[i].alm, tbl[i].fc);
        end

        // Correct code opens, OK relocks
        enter_code(16'h1234);
        apply(1, 0, 0, 0);
        check("open_1234", 16'h0000, 2'd0, 1, 0, 2'd0);
        apply(1, 0, 0, 0);
        check("relock", 16'h0000, 2'd0, 0, 0, 2'd0);

        // Digit wrap and cursor wrap
        repeat (10) apply(0, 0, 0, 1);
        check("inc_wrap", 16'h0000, 2'd0, 0, 0, 2'd0);
        repeat (3) apply(0, 0, 1, 0);
        check("next_x3", 16'h0000, 2'd3, 0, 0, 2'd0);
        apply(0, 0, 1, 0);
        check("next_wrap", 16'h0000, 2'd0, 0, 0, 2'd0);

        // Lockout: three wrong codes, alarm lasts exactly LOCK cycles, INC ignored
        apply(1, 0, 0, 0);
        check("wrong1", 16'h0000, 2'd0, 0, 0, 2'd1);
        apply(1, 0, 0, 0);
        check("wrong2", 16'h0000, 2'd0, 0, 0, 2'd2);
        apply(1, 0, 0, 0);
        check("wrong3", 16'h0000, 2'd0, 0, 1, 2'd3);
        alarm_cycles = 1;
        for (int c = 0; c < 20 && alarm === 1'b1; c++) begin
            apply(0, 0, 0, 1);
            check_model("locked_inc");
            if (alarm === 1'b1) alarm_cycles++;
        end
        vectors++;
        if (alarm_cycles != LOCK) begin
            miscompares++;
            $display("FAIL alarm_len: got %0d cycles expected %0d", alarm_cycles, LOCK);
        end
        check("lock_exit", 16'h0000, 2'd0, 0, 0, 2'd0);

        // Password change while open
        enter_code(16'h1234);
        apply(1, 0, 0, 0);
        check("open_again", 16'h0000, 2'd0, 1, 0, 2'd0);
        enter_code(16'h9876);
        check("open_edit", 16'h9876, 2'd0, 1, 0, 2'd0);
        apply(0, 1, 0, 0);
        check("set_pass", 16'h0000, 2'd0, 1, 0, 2'd0);
        apply(1, 0, 0, 0);
        check("relock2", 16'h0000, 2'd0, 0, 0, 2'd0);
        enter_code(16'h9876);
        apply(1, 0, 0, 0);
        check("open_9876", 16'h0000, 2'd0, 1, 0, 2'd0);
        apply(1, 0, 0, 0);
        enter_code(16'h1234);
        apply(1, 0, 0, 0);
        check("old_pass_rej", 16'h0000, 2'd0, 0, 0, 2'd1);

        // OK and INC together: only OK acts
        apply(0, 0, 0, 1);
        check("pre_okinc", 16'h0001, 2'd0, 0, 0, 2'd1);
        apply(1, 0, 0, 1);
        check("ok_inc", 16'h0000, 2'd0, 0, 0, 2'd2);

        // Reset in LOCKED clears alarm and restores default password
        apply(1, 0, 0, 0);
        check("lock_again", 16'h0000, 2'd0, 0, 1, 2'd3);
        apply(0, 0, 0, 0);
        do_reset();
        check("rst_locked", 16'h0000, 2'd0, 0, 0, 2'd0);
        enter_code(16'h1234);
        apply(1, 0, 0, 0);
        check("default_pass", 16'h0000, 2'd0, 1, 0, 2'd0);

        // Random key streams starting from OPEN
        for (int blk = 0; blk < 10; blk++) begin
            do_reset();
            check_model("rnd_reset");
            enter_code(16'h1234);
            apply(1, 0, 0, 0);
            check_model("rnd_open");
            for (int k = 0; k < 40; k++) begin
                r = $urandom_range(0, 19);
                if (r == 0) apply(1, 0, 0, 0);
                else if (r <= 2) apply(0, 1, 0, 0);
                else if (r <= 7) apply(0, 0, 1, 0);
                else if (r <= 17) apply(0, 0, 0, 1);
                else apply(0, 0, 0, 0);
                check_model("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
